nts_dispatcher: RTL and testbench

Receive-side packet buffer between the Ethernet MAC RX stream and `nts_engine`. It captures one frame of 64-bit words with per-byte valid masks and commits it only when the MAC flags it good. It then presents the committed frame on the dispatch FIFO interface: `packet_available`, `fifo_empty`, `rd_en`/`rd_data`, `data_valid` and `read_discard`. The engine drains the frame and releases the buffer with `read_discard`.

---
 rtl/nts_pkg.sv | 19 +
 rtl/nts_dispatcher_ram.sv | 47 ++++
 rtl/nts_dispatcher.sv | 173 +++++++++++++++++
 tb/tb_nts_dispatcher.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nts_pkg.sv
// rtl/nts_pkg.sv - shared widths, buffer word layout and dispatcher FSM encodings
package nts_pkg;

  localparam int MAC_DATA_W  = 64;
  localparam int MAC_VALID_W = 8;
  localparam int RAM_WORD_W  = MAC_DATA_W + MAC_VALID_W;

  // One buffered MAC word: byte mask on top, data below.
  typedef struct packed {
    logic [MAC_VALID_W-1:0] valid;
    logic [MAC_DATA_W-1:0]  data;
  } ram_word_t;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_WRITING = 2'd1;
  localparam logic [1:0] ST_DROP    = 2'd2;
  localparam logic [1:0] ST_FULL    = 2'd3;

endpackage

// File: rtl/nts_dispatcher_ram.sv
// rtl/nts_dispatcher_ram.sv - simple dual-port frame buffer, synchronous write, registered read
module nts_dispatcher_ram
  import nts_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_areset,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [RAM_WORD_W-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [RAM_WORD_W-1:0] o_rd_data
);

  logic [RAM_WORD_W-1:0] mem_q [2**ADDR_WIDTH];
  logic [RAM_WORD_W-1:0] rd_data_q;
  logic [RAM_WORD_W-1:0] rd_data_d;

  // Storage array: plain write port, no reset so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  // Output register only loads on an accepted read, otherwise holds.
  always_comb begin
    rd_data_d = rd_data_q;
    if (i_rd_en) begin
      rd_data_d = mem_q[i_rd_addr];
    end
  end

  // Output register with reset so the read port starts at zero.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign o_rd_data = rd_data_q;

endmodule

// File: rtl/nts_dispatcher.sv
// rtl/nts_dispatcher.sv - single-frame RX buffer feeding nts_engine; stats built only with NTS_DISPATCHER_STATS_EN
module nts_dispatcher
  import nts_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_areset,
  input  logic [MAC_VALID_W-1:0] i_rx_data_valid,
  input  logic [MAC_DATA_W-1:0]  i_rx_data,
  input  logic                   i_rx_good_frame,
  input  logic                   i_rx_bad_frame,
  output logic                   o_dispatch_packet_available,
  input  logic                   i_dispatch_packet_read_discard,
  output logic [MAC_VALID_W-1:0] o_dispatch_data_valid,
  output logic                   o_dispatch_fifo_empty,
  input  logic                   i_dispatch_fifo_rd_en,
  output logic [MAC_DATA_W-1:0]  o_dispatch_fifo_rd_data,
  output logic [31:0]            o_cnt_good,
  output logic [31:0]            o_cnt_bad,
  output logic [31:0]            o_cnt_dropped
);

  // wr_cnt needs one extra bit so a completely full buffer (2^ADDR_WIDTH) is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

  logic [1:0]          state_q, state_d;
  logic [ADDR_WIDTH:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic                busy_skip_q, busy_skip_d;
  logic                wr_en;
  logic                rd_accept;
  logic                rx_word;
  logic                rx_end;
  ram_word_t           wr_word;
  ram_word_t           rd_word;

  assign rx_word = |i_rx_data_valid;
  assign rx_end  = i_rx_good_frame | i_rx_bad_frame;
  assign wr_word = '{valid: i_rx_data_valid, data: i_rx_data};

  assign o_dispatch_fifo_empty = (state_q != ST_FULL) || (rd_ptr_q == wr_cnt_q);
  assign rd_accept             = i_dispatch_fifo_rd_en && !o_dispatch_fifo_empty;

  // Frame capture FSM plus the skip flag that swallows frames arriving while a frame is held.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    busy_skip_d = busy_skip_q;
    wr_en       = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        // A frame that began while FULL is still being skipped even after a discard.
        if (rx_word && !busy_skip_q) begin
          wr_en    = 1'b1;
          wr_cnt_d = CNT_ONE;
          state_d  = ST_WRITING;
        end
      end
      ST_WRITING: begin
        if (i_rx_good_frame) begin
          state_d = ST_FULL;
        end else if (i_rx_bad_frame) begin
          state_d  = ST_EMPTY;
          wr_cnt_d = '0;
        end else if (rx_word) begin
          if (wr_cnt_q == DEPTH) begin
            state_d = ST_DROP;
          end else begin
            wr_en    = 1'b1;
            wr_cnt_d = wr_cnt_q + CNT_ONE;
          end
        end
      end
      ST_DROP: begin
        if (rx_end) begin
          state_d  = ST_EMPTY;
          wr_cnt_d = '0;
        end
      end
      default: begin
        if (rd_accept) begin
          rd_ptr_d = rd_ptr_q + CNT_ONE;
        end
        if (i_dispatch_packet_read_discard) begin
          state_d  = ST_EMPTY;
          rd_ptr_d = '0;
          wr_cnt_d = '0;
        end
      end
    endcase
    if (busy_skip_q) begin
      if (rx_end) begin
        busy_skip_d = 1'b0;
      end
    end else if (state_q == ST_FULL && rx_word) begin
      busy_skip_d = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state_q     <= ST_EMPTY;
      wr_cnt_q    <= '0;
      rd_ptr_q    <= '0;
      busy_skip_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      busy_skip_q <= busy_skip_d;
    end
  end

  nts_dispatcher_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .i_clk     (i_clk),
    .i_areset  (i_areset),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_cnt_q[ADDR_WIDTH-1:0]),
    .i_wr_data (wr_word),
    .i_rd_en   (rd_accept),
    .i_rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .o_rd_data (rd_word)
  );

  assign o_dispatch_packet_available = (state_q == ST_FULL);
  assign o_dispatch_data_valid       = rd_word.valid;
  assign o_dispatch_fifo_rd_data     = rd_word.data;

`ifdef NTS_DISPATCHER_STATS_EN
  logic [31:0] cnt_good_q, cnt_good_d;
  logic [31:0] cnt_bad_q, cnt_bad_d;
  logic [31:0] cnt_dropped_q, cnt_dropped_d;
  logic        good_inc, bad_inc, drop_inc;

  // Frame outcome counters; the good pulse wins if both pulses ever coincide.
  always_comb begin
    good_inc      = (state_q == ST_WRITING) && i_rx_good_frame;
    bad_inc       = (state_q == ST_WRITING) && !i_rx_good_frame && i_rx_bad_frame;
    drop_inc      = rx_end && ((state_q == ST_DROP) || busy_skip_q);
    cnt_good_d    = cnt_good_q + {31'd0, good_inc};
    cnt_bad_d     = cnt_bad_q + {31'd0, bad_inc};
    cnt_dropped_d = cnt_dropped_q + {31'd0, drop_inc};
  end

  // Counter registers, wrapping naturally at 2^32.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      cnt_good_q    <= '0;
      cnt_bad_q     <= '0;
      cnt_dropped_q <= '0;
    end else begin
      cnt_good_q    <= cnt_good_d;
      cnt_bad_q     <= cnt_bad_d;
      cnt_dropped_q <= cnt_dropped_d;
    end
  end

  assign o_cnt_good    = cnt_good_q;
  assign o_cnt_bad     = cnt_bad_q;
  assign o_cnt_dropped = cnt_dropped_q;
`else
  assign o_cnt_good    = '0;
  assign o_cnt_bad     = '0;
  assign o_cnt_dropped = '0;
`endif

endmodule

// File: tb/tb_nts_dispatcher.sv
// tb/tb_nts_dispatcher.sv - randomized self-checking bench for nts_dispatcher against a frame-level model
module tb_nts_dispatcher;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef NTS_DISPATCHER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_valid;
  logic [63:0] rx_data;
  logic        rx_good, rx_bad;
  logic        avail;
  logic        discard;
  logic [7:0]  dv;
  logic        empty;
  logic        rd_en;
  logic [63:0] rd_data;
  logic [31:0] cnt_good, cnt_bad, cnt_dropped;

  int total = 0;
  int bad   = 0;

  // model: held frame contents and frame statistics
  logic [63:0] fd[$];
  logic [7:0]  fv[$];
  logic [63:0] hd[$];
  logic [7:0]  hv[$];
  bit          m_held;
  int unsigned m_good, m_bad, m_drop;

  nts_dispatcher #(.ADDR_WIDTH(AW)) dut (
    .i_clk                          (clk),
    .i_areset                       (rst),
    .i_rx_data_valid                (rx_valid),
    .i_rx_data                      (rx_data),
    .i_rx_good_frame                (rx_good),
    .i_rx_bad_frame                 (rx_bad),
    .o_dispatch_packet_available    (avail),
    .i_dispatch_packet_read_discard (discard),
    .o_dispatch_data_valid          (dv),
    .o_dispatch_fifo_empty          (empty),
    .i_dispatch_fifo_rd_en          (rd_en),
    .o_dispatch_fifo_rd_data        (rd_data),
    .o_cnt_good                     (cnt_good),
    .o_cnt_bad                      (cnt_bad),
    .o_cnt_dropped                  (cnt_dropped)
  );

  always #5 clk = ~clk;

  function automatic logic [95:0] exp_stats();
    if (STATS) return {m_good, m_bad, m_drop};
    return 96'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_held = 1'b0;
    m_good = 0;
    m_bad  = 0;
    m_drop = 0;
  endtask

  task automatic build_frame(input int len, input logic [7:0] last);
    fd.delete();
    fv.delete();
    for (int i = 0; i < len; i++) begin
      fd.push_back({$urandom, $urandom});
      fv.push_back((i == len - 1) ? last : 8'hFF);
    end
  endtask

  // Sends the current frame; optionally pulses read_discard alongside its first word.
  task automatic send_frame(input bit good, input bit discard_first);
    bit was_held;
    was_held = m_held;
    for (int i = 0; i < fd.size(); i++) begin
      rx_valid = fv[i];
      rx_data  = fd[i];
      discard  = discard_first && (i == 0);
      step();
      discard  = 1'b0;
    end
    if (discard_first) m_held = 1'b0;
    rx_valid = '0;
    rx_data  = '0;
    rx_good  = good;
    rx_bad   = !good;
    step();
    rx_good  = 1'b0;
    rx_bad   = 1'b0;
    if (was_held || fd.size() > DEPTH) begin
      m_drop++;
    end else if (good) begin
      m_held = 1'b1;
      hd = fd;
      hv = fv;
      m_good++;
    end else begin
      m_bad++;
    end
  endtask

  task automatic read_words(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      step();
      total++;
      if ({dv, rd_data} !== {hv[i], hd[i]}) begin
        bad++;
        $display("FAIL %s_word%0d: got %h/%h want %h/%h", tag, i, dv, rd_data, hv[i], hd[i]);
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic do_discard(input string tag);
    discard = 1'b1;
    step();
    discard = 1'b0;
    m_held  = 1'b0;
    total++;
    if (avail !== 1'b0) begin
      bad++;
      $display("FAIL %s_discard_avail: got %b want 0", tag, avail);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = '0; rx_data = '0; rx_good = 0; rx_bad = 0; discard = 0; rd_en = 0;
    model_reset();
    step(); step();
    rst = 1'b0;
    step();
    total++;
    if ({avail, empty, dv, rd_data} !== {1'b0, 1'b1, 8'h00, 64'h0}) begin
      bad++;
      $display("FAIL reset_outputs: got %b %b %h %h want 0 1 00 0", avail, empty, dv, rd_data);
    end
    total++;
    if ({cnt_good, cnt_bad, cnt_dropped} !== exp_stats()) begin
      bad++;
      $display("FAIL reset_stats: got %0d %0d %0d want 0 0 0", cnt_good, cnt_bad, cnt_dropped);
    end
  endtask

  task automatic test_good_frame();
    build_frame(12, 8'hC0);
    send_frame(1'b1, 1'b0);
    total++;
    if ({avail, empty} !== 2'b10) begin
      bad++;
      $display("FAIL good_avail: got avail=%b empty=%b want 1 0", avail, empty);
    end
    read_words(12, "good");
    total++;
    if ({empty, dv} !== {1'b1, 8'hC0}) begin
      bad++;
      $display("FAIL good_end: got empty=%b dv=%h want 1 c0", empty, dv);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    total++;
    if ({empty, dv, rd_data} !== {1'b1, hv[11], hd[11]}) begin
      bad++;
      $display("FAIL good_rd_when_empty: got %b %h %h want 1 %h %h", empty, dv, rd_data, hv[11], hd[11]);
    end
    total++;
    if ({cnt_good, cnt_bad, cnt_dropped} !== exp_stats()) begin
      bad++;
      $display("FAIL good_stats: got %0d %0d %0d want %h", cnt_good, cnt_bad, cnt_dropped, exp_stats());
    end
    do_discard("good");
  endtask

  task automatic test_bad_frame();
    build_frame(12, 8'hC0);
    send_frame(1'b0, 1'b0);
    step();
    total++;
    if ({avail, cnt_good, cnt_bad, cnt_dropped} !== {1'b0, exp_stats()}) begin
      bad++;
      $display("FAIL bad_frame: got avail=%b %0d %0d %0d", avail, cnt_good, cnt_bad, cnt_dropped);
    end
    build_frame(7, 8'hF0);
    send_frame(1'b1, 1'b0);
    total++;
    if (avail !== 1'b1) begin
      bad++;
      $display("FAIL bad_next_avail: got %b want 1", avail);
    end
    read_words(7, "bad_next");
    do_discard("bad_next");
  endtask

  task automatic test_busy_drop();
    build_frame(12, 8'hC0);
    send_frame(1'b1, 1'b0);
    build_frame(9, 8'hFE);
    send_frame(1'b1, 1'b0);
    total++;
    if ({avail, cnt_good, cnt_bad, cnt_dropped} !== {1'b1, exp_stats()}) begin
      bad++;
      $display("FAIL busy_state: got avail=%b %0d %0d %0d want %h", avail, cnt_good, cnt_bad, cnt_dropped, exp_stats());
    end
    read_words(12, "busy_first");
    do_discard("busy");
    build_frame(5, 8'h80);
    send_frame(1'b1, 1'b0);
    read_words(5, "busy_third");
    build_frame(3, 8'hFF);
    send_frame(1'b1, 1'b1);
    total++;
    if ({avail, cnt_good, cnt_bad, cnt_dropped} !== {1'b0, exp_stats()}) begin
      bad++;
      $display("FAIL discard_collision: got avail=%b %0d %0d %0d want %h", avail, cnt_good, cnt_bad, cnt_dropped, exp_stats());
    end
  endtask

  task automatic test_overflow();
    build_frame(20, 8'hFF);
    send_frame(1'b1, 1'b0);
    total++;
    if ({avail, empty, cnt_good, cnt_bad, cnt_dropped} !== {2'b01, exp_stats()}) begin
      bad++;
      $display("FAIL overflow: got avail=%b empty=%b %0d %0d %0d", avail, empty, cnt_good, cnt_bad, cnt_dropped);
    end
    build_frame(DEPTH, 8'hF8);
    send_frame(1'b1, 1'b0);
    total++;
    if (avail !== 1'b1) begin
      bad++;
      $display("FAIL exact_depth_avail: got %b want 1", avail);
    end
    read_words(DEPTH, "exact_depth");
    total++;
    if (empty !== 1'b1) begin
      bad++;
      $display("FAIL exact_depth_empty: got %b want 1", empty);
    end
    do_discard("exact_depth");
  endtask

  task automatic test_early_discard();
    build_frame(12, 8'hC0);
    send_frame(1'b1, 1'b0);
    read_words(3, "early");
    do_discard("early");
    build_frame(6, 8'hFC);
    send_frame(1'b1, 1'b0);
    read_words(6, "early_next");
    total++;
    if (empty !== 1'b1) begin
      bad++;
      $display("FAIL early_next_empty: got %b want 1", empty);
    end
    do_discard("early_next");
  endtask

  task automatic test_reset_mid();
    build_frame(12, 8'hC0);
    for (int i = 0; i < 5; i++) begin
      rx_valid = fv[i];
      rx_data  = fd[i];
      step();
    end
    rx_valid = '0;
    rx_data  = '0;
    rst = 1'b1;
    #2;
    model_reset();
    total++;
    if ({avail, empty, dv, rd_data, cnt_good, cnt_bad, cnt_dropped} !== {2'b01, 72'h0, 96'h0}) begin
      bad++;
      $display("FAIL reset_mid: got %b %b %h %h %0d %0d %0d", avail, empty, dv, rd_data, cnt_good, cnt_bad, cnt_dropped);
    end
    step();
    rst = 1'b0;
    step();
    build_frame(12, 8'hC0);
    send_frame(1'b1, 1'b0);
    total++;
    if ({avail, cnt_good, cnt_bad, cnt_dropped} !== {1'b1, exp_stats()}) begin
      bad++;
      $display("FAIL reset_mid_next: got avail=%b %0d %0d %0d", avail, cnt_good, cnt_bad, cnt_dropped);
    end
    read_words(12, "reset_mid_next");
    do_discard("reset_mid_next");
  endtask

  task automatic test_random();
    logic [7:0] last;
    for (int it = 0; it < 40; it++) begin
      last = 8'hFF;
      last = last << $urandom_range(0, 7);
      build_frame($urandom_range(1, DEPTH + 3), last);
      send_frame($urandom_range(0, 3) != 0, 1'b0);
      step();
      total++;
      if ({avail, cnt_good, cnt_bad, cnt_dropped} !== {m_held, exp_stats()}) begin
        bad++;
        $display("FAIL rand%0d_state: got avail=%b %0d %0d %0d want %b %h", it, avail, cnt_good, cnt_bad, cnt_dropped, m_held, exp_stats());
      end
      if (m_held && $urandom_range(0, 2) != 0) begin
        read_words(hd.size(), "rand");
        total++;
        if (empty !== 1'b1) begin
          bad++;
          $display("FAIL rand%0d_empty: got %b want 1", it, empty);
        end
        do_discard("rand");
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_frame();
    test_busy_drop();
    test_overflow();
    test_early_discard();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
